// File: rtl/ds_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ds_pkg
// Brief   : Shared FSM state encoding and default widths for the DS sink.
// Revision: 1.0 - initial release
// ============================================================================
package ds_pkg;

    localparam int c_DEF_DATA_W = 8;
    localparam int c_DEF_LEN_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } ds_state_t;

endpackage
`default_nettype wire

// File: rtl/ds_sink_fifo.sv
`default_nettype none
// ============================================================================
// Module  : ds_sink_fifo
// Brief   : Synchronous show-ahead FIFO; full/empty derived from a pointer MSB.
// Revision: 1.0 - initial release
// ============================================================================
module ds_sink_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int c_AW = $clog2(FIFO_DEPTH);

    logic [c_AW:0]       r_wr_ptr;
    logic [c_AW:0]       r_rd_ptr;
    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic                w_wr;
    logic                w_rd;

    assign w_wr = wr_en && !full;
    assign w_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[c_AW-1:0]] <= wr_data;
    end

    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign rd_data = r_mem[r_rd_ptr[c_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/ds_sink.sv
`default_nettype none
// ============================================================================
// Module  : ds_sink
// Brief   : DS stream receiver: accepts one armed packet into a FIFO and checks
//           its length. Optional byte pattern checker: DS_SINK_PATTERN_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module ds_sink
    import ds_pkg::*;
#(
    parameter int DATA_W     = c_DEF_DATA_W,
    parameter int LEN_W      = c_DEF_LEN_W,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic [LEN_W-1:0]  exp_len,
    input  logic              EN,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    input  logic              last,
    output logic              ready,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_empty,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  rx_len,
    output logic              len_err,
    output logic              data_err
);

    localparam logic [LEN_W-1:0] c_LEN_MAX = '1;

    ds_state_t          r_state;
    ds_state_t          w_state_nxt;
    logic [LEN_W-1:0]   r_exp_len;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   w_cnt_inc;
    logic               w_at_max;
    logic               w_full;
    logic               w_start;
    logic               w_xfer;

    assign w_start   = (r_state == ST_IDLE) && arm && (exp_len != '0);
    assign ready     = (r_state == ST_RECV) && !w_full;
    assign w_xfer    = EN && valid && ready;
    assign busy      = (r_state == ST_RECV);
    assign done      = (r_state == ST_DONE);
    assign w_at_max  = (r_cnt == c_LEN_MAX);
    assign w_cnt_inc = w_at_max ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = ST_RECV;
            ST_RECV: if (w_xfer && last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A byte arriving while the counter is already at max means the packet
    // overran the counter, so it is a length error regardless of exp_len.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp_len <= '0;
            r_cnt     <= '0;
            rx_len    <= '0;
            len_err   <= 1'b0;
        end else if (w_start) begin
            r_exp_len <= exp_len;
            r_cnt     <= '0;
            len_err   <= 1'b0;
        end else if (w_xfer) begin
            r_cnt <= w_cnt_inc;
            if (last) begin
                rx_len  <= w_cnt_inc;
                len_err <= w_at_max || (w_cnt_inc != r_exp_len);
            end
        end
    end

`ifdef DS_SINK_PATTERN_CHECK_EN
    logic [DATA_W-1:0] r_exp_byte;
    logic              r_data_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp_byte <= '0;
            r_data_err <= 1'b0;
        end else if (w_start) begin
            r_exp_byte <= '0;
            r_data_err <= 1'b0;
        end else if (w_xfer) begin
            r_exp_byte <= r_exp_byte + 1'b1;
            if (data != r_exp_byte) r_data_err <= 1'b1;
        end
    end

    assign data_err = r_data_err;
`else
    assign data_err = 1'b0;
`endif

    ds_sink_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_xfer),
        .wr_data (data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .full    (w_full),
        .empty   (rd_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_ds_sink.sv
`default_nettype none
// ============================================================================
// Module  : tb_ds_sink
// Brief   : Self-checking bench for ds_sink (small FIFO, queue reference model).
// Revision: 1.0 - initial release
// ============================================================================
module tb_ds_sink;

    localparam int c_DEPTH = 4;
`ifdef DS_SINK_PATTERN_CHECK_EN
    localparam bit c_PAT = 1'b1;
`else
    localparam bit c_PAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arm = 1'b0;
    logic [7:0] exp_len = '0;
    logic       EN = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data = '0;
    logic       last = 1'b0;
    logic       ready;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_empty;
    logic       busy;
    logic       done;
    logic [7:0] rx_len;
    logic       len_err;
    logic       data_err;

    always #5 clk = ~clk;

    ds_sink #(.DATA_W(8), .LEN_W(8), .FIFO_DEPTH(c_DEPTH)) dut (
        .clk(clk), .rst(rst), .arm(arm), .exp_len(exp_len), .EN(EN),
        .valid(valid), .data(data), .last(last), .ready(ready),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .busy(busy),
        .done(done), .rx_len(rx_len), .len_err(len_err), .data_err(data_err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 idle, 1 receiving, 2 done; unbounded byte count.
    int         m_mode = 0;
    logic [7:0] m_q[$];
    int         m_cnt = 0;
    int         m_exp = 0;
    logic [7:0] m_rx = '0;
    bit         m_lerr = 1'b0;
    bit         m_derr = 1'b0;
    logic [7:0] popped[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_edge();
        bit x;
        if (rst) begin
            m_mode = 0; m_q.delete(); m_cnt = 0; m_rx = '0; m_lerr = 0; m_derr = 0;
        end else begin
            x = EN && valid && (m_mode == 1) && (m_q.size() < c_DEPTH);
            if (rd_en && m_q.size() > 0) void'(m_q.pop_front());
            if (x) m_q.push_back(data);
            case (m_mode)
                0: if (arm && exp_len != 0) begin
                       m_mode = 1; m_exp = int'(exp_len); m_cnt = 0; m_lerr = 0; m_derr = 0;
                   end
                1: if (x) begin
                       if (c_PAT && data != 8'(m_cnt)) m_derr = 1;
                       m_cnt++;
                       if (last) begin
                           m_rx   = (m_cnt > 255) ? 8'd255 : 8'(m_cnt);
                           m_lerr = (m_cnt != m_exp);
                           m_mode = 2;
                       end
                   end
                default: m_mode = 0;
            endcase
        end
    endtask

    task automatic tick();
        if (rd_en && !rd_empty) popped.push_back(rd_data);
        model_edge();
        @(posedge clk);
        #1;
        chk("ready",    ready,    32'((m_mode == 1) && (m_q.size() < c_DEPTH)));
        chk("rd_empty", rd_empty, 32'(m_q.size() == 0));
        chk("busy",     busy,     32'(m_mode == 1));
        chk("done",     done,     32'(m_mode == 2));
        chk("rx_len",   rx_len,   32'(m_rx));
        chk("len_err",  len_err,  32'(m_lerr));
        chk("data_err", data_err, 32'(m_derr));
        if (m_q.size() > 0) chk("rd_data", rd_data, 32'(m_q[0]));
    endtask

    task automatic do_arm(input logic [7:0] n);
        arm = 1'b1; exp_len = n;
        tick();
        arm = 1'b0;
    endtask

    // Offer one byte until accepted; optionally pop one word whenever stalled.
    task automatic push_byte(input logic [7:0] d, input bit l, input bit unstall);
        bit acc = 1'b0;
        EN = 1'b1; valid = 1'b1; data = d; last = l;
        for (int k = 0; k < 64 && !acc; k++) begin
            acc = ready;
            if (!acc && unstall) begin
                rd_en = 1'b1; tick(); rd_en = 1'b0;
            end else begin
                tick();
            end
        end
        if (!acc) chk("xfer_timeout", 0, 1);
        EN = 1'b0; valid = 1'b0; last = 1'b0;
    endtask

    task automatic drain();
        rd_en = 1'b1;
        for (int k = 0; k < 64 && !rd_empty; k++) tick();
        rd_en = 1'b0;
        chk("drain_empty", rd_empty, 1);
    endtask

    typedef struct {
        logic [4:0] ctl;   // {arm, EN, valid, last, rd_en}
        logic [7:0] len;
        logic [7:0] dat;
        logic [4:0] xp;    // {ready, rd_empty, busy, done, len_err}
    } vec_t;

    vec_t tbl[14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 5; i++) tbl[i] = '{5'b01100, 8'd0, 8'd0, 5'b01000};
        tbl[5]  = '{5'b11100, 8'd0, 8'd0, 5'b01000};
        tbl[6]  = '{5'b11100, 8'd3, 8'd0, 5'b11100};
        tbl[7]  = '{5'b01100, 8'd0, 8'd0, 5'b10100};
        tbl[8]  = '{5'b11100, 8'd9, 8'd1, 5'b10100};
        tbl[9]  = '{5'b01110, 8'd0, 8'd2, 5'b00010};
        tbl[10] = '{5'b00001, 8'd0, 8'd0, 5'b00000};
        tbl[11] = '{5'b00001, 8'd0, 8'd0, 5'b00000};
        tbl[12] = '{5'b00001, 8'd0, 8'd0, 5'b01000};
        tbl[13] = '{5'b00001, 8'd0, 8'd0, 5'b01000};

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_ready", ready, 0);
        chk("rst_empty", rd_empty, 1);

        // Idle hold-off, zero-length arm, arm ignored while receiving
        for (int i = 0; i < 14; i++) begin
            {arm, EN, valid, last, rd_en} = tbl[i].ctl;
            exp_len = tbl[i].len;
            data    = tbl[i].dat;
            tick();
            chk($sformatf("tbl%0d_ready", i), ready,    tbl[i].xp[4]);
            chk($sformatf("tbl%0d_empty", i), rd_empty, tbl[i].xp[3]);
            chk($sformatf("tbl%0d_busy", i),  busy,     tbl[i].xp[2]);
            chk($sformatf("tbl%0d_done", i),  done,     tbl[i].xp[1]);
            chk($sformatf("tbl%0d_lerr", i),  len_err,  tbl[i].xp[0]);
        end
        {arm, EN, valid, last, rd_en} = 5'b0;
        chk("tbl_rx_len", rx_len, 3);

        // Nominal 8-byte packet, reader draining concurrently
        popped.delete();
        do_arm(8'd8);
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) push_byte(8'(i), i == 7, 1'b0);
        chk("t1_done", done, 1);
        chk("t1_rx_len", rx_len, 8);
        chk("t1_len_err", len_err, 0);
        chk("t1_data_err", data_err, 0);
        rd_en = 1'b0;
        drain();
        chk("t1_count", popped.size(), 8);
        for (int i = 0; i < popped.size(); i++) chk("t1_order", popped[i], i);

        // Short and long packets
        rd_en = 1'b1;
        do_arm(8'd8);
        for (int i = 0; i < 6; i++) push_byte(8'(i), i == 5, 1'b0);
        chk("t2s_rx_len", rx_len, 6);
        chk("t2s_len_err", len_err, 1);
        tick();
        do_arm(8'd8);
        for (int i = 0; i < 9; i++) push_byte(8'(i), i == 8, 1'b0);
        chk("t2l_rx_len", rx_len, 9);
        chk("t2l_len_err", len_err, 1);
        tick();
        drain();

        // Backpressure with full FIFO
        popped.delete();
        do_arm(8'd8);
        for (int i = 0; i < 4; i++) push_byte(8'(i), 1'b0, 1'b0);
        tick();
        chk("t3_full_ready", ready, 0);
        for (int i = 4; i < 8; i++) push_byte(8'(i), i == 7, 1'b1);
        chk("t3_rx_len", rx_len, 8);
        tick();
        drain();
        chk("t3_count", popped.size(), 8);
        for (int i = 0; i < popped.size(); i++) chk("t3_order", popped[i], i);

        // Reset mid-packet, then re-arm
        do_arm(8'd8);
        for (int i = 0; i < 3; i++) push_byte(8'(i), 1'b0, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t5_ready", ready, 0);
        chk("t5_empty", rd_empty, 1);
        chk("t5_busy", busy | done | len_err | data_err, 0);
        chk("t5_rx_len", rx_len, 0);
        rd_en = 1'b1;
        do_arm(8'd8);
        for (int i = 0; i < 8; i++) push_byte(8'(i), i == 7, 1'b0);
        chk("t5_rearm_rx", rx_len, 8);
        chk("t5_rearm_err", len_err, 0);
        tick();

        // Pattern corruption on byte 3
        do_arm(8'd5);
        for (int i = 0; i < 5; i++) push_byte((i == 3) ? 8'hAA : 8'(i), i == 4, 1'b0);
        chk("t6_derr_done", data_err, c_PAT);
        chk("t6_len_err", len_err, 0);
        tick(); tick();
        chk("t6_derr_sticky", data_err, c_PAT);
        do_arm(8'd2);
        chk("t6_derr_clear", data_err, 0);
        for (int i = 0; i < 2; i++) push_byte(8'(i), i == 1, 1'b0);
        tick();

        // Counter saturation: exactly max bytes, then one more than max
        do_arm(8'd255);
        for (int i = 0; i < 255; i++) push_byte(8'(i), i == 254, 1'b0);
        chk("sat_exact_rx", rx_len, 255);
        chk("sat_exact_err", len_err, 0);
        tick();
        do_arm(8'd255);
        for (int i = 0; i < 256; i++) push_byte(8'(i), i == 255, 1'b0);
        chk("sat_over_rx", rx_len, 255);
        chk("sat_over_err", len_err, 1);
        tick();
        rd_en = 1'b0;

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 299) == 0);
            arm     = ($urandom_range(0, 15) == 0);
            exp_len = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 10));
            EN      = ($urandom_range(0, 3) != 0);
            valid   = ($urandom_range(0, 3) != 0);
            data    = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(m_cnt);
            last    = ($urandom_range(0, 7) == 0);
            rd_en   = ($urandom_range(0, 1) == 0);
            tick();
        end
        {rst, arm, EN, valid, last, rd_en} = 6'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
